// File: rtl/uart_tx_tick.sv
// uart_tx_tick: tick-paced UART transmitter (start, NB_DATA bits LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_tick #(
   parameter int NB_DATA = 8,
   parameter int OVS     = 16
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_data,
   output logic               o_tx,
   output logic               o_busy,
   output logic               o_tx_done
);

   localparam int TICK_W = $clog2(OVS);
   localparam int BIT_W  = $clog2(NB_DATA);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd3
   } state_t;

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [NB_DATA-1:0] d);
      return ^d;
   endfunction
`endif

   state_t               state_r;
   state_t               state_nxt_s;
   logic [TICK_W-1:0]    tick_cnt_r;
   logic [TICK_W-1:0]    tick_cnt_nxt_s;
   logic [BIT_W-1:0]     bit_cnt_r;
   logic [BIT_W-1:0]     bit_cnt_nxt_s;
   logic [NB_DATA-1:0]   shift_r;
   logic [NB_DATA-1:0]   shift_nxt_s;
`ifdef UART_TX_PARITY_EN
   logic                 parity_r;
   logic                 parity_nxt_s;
`endif
   logic                 bit_end_s;
   logic                 tx_nxt_s;
   logic                 busy_nxt_s;
   logic                 done_nxt_s;

   // A bit ends on the clock that carries its OVS-th tick.
   assign bit_end_s = i_tick && (tick_cnt_r == TICK_LAST);

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_r    <= ST_IDLE;
         tick_cnt_r <= {TICK_W{1'b0}};
         bit_cnt_r  <= {BIT_W{1'b0}};
         shift_r    <= {NB_DATA{1'b0}};
`ifdef UART_TX_PARITY_EN
         parity_r   <= 1'b0;
`endif
      end else begin
         state_r    <= state_nxt_s;
         tick_cnt_r <= tick_cnt_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         shift_r    <= shift_nxt_s;
`ifdef UART_TX_PARITY_EN
         parity_r   <= parity_nxt_s;
`endif
      end
   end

   // Next-state, tick counter, bit counter and shift register.
   always_comb begin
      state_nxt_s   = state_r;
      bit_cnt_nxt_s = bit_cnt_r;
      shift_nxt_s   = shift_r;
`ifdef UART_TX_PARITY_EN
      parity_nxt_s  = parity_r;
`endif

      if (state_r == ST_IDLE) begin
         tick_cnt_nxt_s = {TICK_W{1'b0}};
      end else if (bit_end_s) begin
         tick_cnt_nxt_s = {TICK_W{1'b0}};
      end else if (i_tick) begin
         tick_cnt_nxt_s = tick_cnt_r + TICK_W'(1);
      end else begin
         tick_cnt_nxt_s = tick_cnt_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (i_tx_start) begin
               state_nxt_s   = ST_START;
               shift_nxt_s   = i_data;
               bit_cnt_nxt_s = {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
               parity_nxt_s  = even_parity(i_data);
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_nxt_s   = ST_DATA;
               bit_cnt_nxt_s = {BIT_W{1'b0}};
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               shift_nxt_s = {1'b0, shift_r[NB_DATA-1:1]};
               if (bit_cnt_r == BIT_LAST) begin
                  bit_cnt_nxt_s = {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                  state_nxt_s   = ST_PARITY;
`else
                  state_nxt_s   = ST_STOP;
`endif
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end_s) begin
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            bit_cnt_nxt_s  = {BIT_W{1'b0}};
            shift_nxt_s    = {NB_DATA{1'b0}};
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered line changes with the state.
   always_comb begin
      busy_nxt_s = (state_nxt_s != ST_IDLE);
      done_nxt_s = (state_r == ST_STOP) && (state_nxt_s == ST_IDLE);
      case (state_nxt_s)
         ST_IDLE:   tx_nxt_s = 1'b1;
         ST_START:  tx_nxt_s = 1'b0;
         ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_nxt_s = parity_r;
`endif
         ST_STOP:   tx_nxt_s = 1'b1;
         default:   tx_nxt_s = 1'b1;
      endcase
   end

   // Output registers.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         o_tx      <= 1'b1;
         o_busy    <= 1'b0;
         o_tx_done <= 1'b0;
      end else begin
         o_tx      <= tx_nxt_s;
         o_busy    <= busy_nxt_s;
         o_tx_done <= done_nxt_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: vector table plus tick-counting receiver scoreboard.
// Honours UART_TX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_tx_tick;

   localparam int NB_DATA = 8;
   localparam int OVS     = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FB = NB_DATA + 3;
`else
   localparam int FB = NB_DATA + 2;
`endif

   typedef struct {
      logic [7:0] data;
      int         period;
   } vec_t;

   logic       clock;
   logic       i_reset;
   logic       i_tick;
   logic       i_tx_start;
   logic [7:0] i_data;
   logic       o_tx;
   logic       o_busy;
   logic       o_tx_done;

   int          n_cmp;
   int          n_bad;
   logic [15:0] exp_q[$];
   int          tick_period;
   bit          tick_gate;
   int          tick_total;
   int          aborts_allowed;
   int          aborts_seen;

   uart_tx_tick #(.NB_DATA(NB_DATA), .OVS(OVS)) dut (
      .clock      (clock),
      .i_reset    (i_reset),
      .i_tick     (i_tick),
      .i_tx_start (i_tx_start),
      .i_data     (i_data),
      .o_tx       (o_tx),
      .o_busy     (o_busy),
      .o_tx_done  (o_tx_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference frame, bit 0 is the first bit on the line.
   function automatic logic [15:0] frame_of(input logic [7:0] d);
      logic [15:0] f;
      f = 16'h0000;
      for (int i = 0; i < NB_DATA; i++) f[i + 1] = d[i];
`ifdef UART_TX_PARITY_EN
      f[NB_DATA + 1] = ^d;
`endif
      f[FB - 1] = 1'b1;
      return f;
   endfunction

   // Tick source: one strobe every tick_period clocks, changed just after negedge.
   initial begin
      int phase;
      phase  = 0;
      i_tick = 1'b0;
      forever begin
         @(negedge clock);
         #2;
         i_tick = tick_gate && (phase == 0);
         phase  = (phase + 1 >= tick_period) ? 0 : phase + 1;
      end
   end

   initial begin
      tick_total = 0;
      forever begin
         @(posedge clock);
         if (i_tick) tick_total++;
      end
   end

   // Receiver: counts ticks since the frame began and samples o_tx mid-bit.
   initial begin
      bit          rx_active;
      bit          busy_q;
      int          tick_base;
      int          rx_idx;
      logic [15:0] rx_bits;
      rx_active   = 1'b0;
      busy_q      = 1'b0;
      tick_base   = 0;
      rx_idx      = 0;
      rx_bits     = 16'h0000;
      aborts_seen = 0;
      forever begin
         @(negedge clock);
         if (!rx_active) begin
            if (o_busy && !busy_q) begin
               rx_active = 1'b1;
               tick_base = tick_total;
               rx_idx    = 0;
               rx_bits   = 16'h0000;
            end
         end else if (!o_busy) begin
            if (aborts_seen < aborts_allowed) begin
               aborts_seen++;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
               check("busy_mid_frame", int'(o_busy), 1);
            end
            rx_active = 1'b0;
         end else if ((tick_total - tick_base) == rx_idx * OVS + OVS / 2) begin
            rx_bits[rx_idx] = o_tx;
            rx_idx++;
            if (rx_idx == FB) begin
               if (exp_q.size() == 0) begin
                  check("frame_expected", exp_q.size(), 1);
               end else begin
                  check("frame", int'(rx_bits), int'(exp_q.pop_front()));
               end
               rx_active = 1'b0;
            end
         end
         busy_q = o_busy;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_idle();
      int k;
      k = 0;
      while (o_busy && k < 20000) begin
         @(negedge clock);
         k++;
      end
      if (o_busy) check("idle_timeout", int'(o_busy), 0);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clock);
         if (o_tx_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", int'(seen), 1);
   endtask

   // Start a frame so its accepting edge carries a tick; returns at negedge of first busy cycle.
   task automatic send(input logic [7:0] d);
      wait_idle();
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         #3;
         if (i_tick) break;
      end
      i_data     = d;
      i_tx_start = 1'b1;
      exp_q.push_back(frame_of(d));
      @(negedge clock);
      i_tx_start = 1'b0;
   endtask

   initial begin
      vec_t        vecs[7];
      logic [15:0] exp_a5;
      int          busy_cnt;
      bit          done_seen;
      bit          done_any;
      int          n;

      vecs[0] = '{8'hA5, 1};
      vecs[1] = '{8'h3C, 4};
      vecs[2] = '{8'h00, 1};
      vecs[3] = '{8'hFF, 2};
      vecs[4] = '{8'h07, 3};
      vecs[5] = '{8'h03, 1};
      vecs[6] = '{8'h5A, 5};
`ifdef UART_TX_PARITY_EN
      exp_a5 = 16'b00000_10101001010;
`else
      exp_a5 = 16'b000000_1101001010;
`endif

      n_cmp          = 0;
      n_bad          = 0;
      tick_period    = 1;
      tick_gate      = 1'b1;
      aborts_allowed = 0;
      i_reset        = 1'b1;
      i_tx_start     = 1'b1;
      i_data         = 8'h00;

      // Reset dominates a pending start and ticks.
      repeat (4) @(negedge clock);
      check("rst_tx", int'(o_tx), 1);
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_tx_done), 0);
      i_tx_start = 1'b0;
      @(negedge clock);
      i_reset = 1'b0;
      repeat (3) @(negedge clock);
      check("idle_tx", int'(o_tx), 1);

      // 0xA5, tick every clock: cycle-exact line shape and done timing.
      tick_period = 1;
      send(8'hA5);
      for (int c = 0; c < FB * OVS; c++) begin
         check($sformatf("a5_tx_c%0d", c), int'(o_tx), int'(exp_a5[c / OVS]));
         check($sformatf("a5_busy_c%0d", c), int'(o_busy), 1);
         @(negedge clock);
      end
      check("a5_done", int'(o_tx_done), 1);
      check("a5_done_busy", int'(o_busy), 0);
      @(negedge clock);
      check("a5_done_width", int'(o_tx_done), 0);

      // Vector table: frame length in clocks at several tick rates.
      for (int i = 0; i < 7; i++) begin
         tick_period = vecs[i].period;
         send(vecs[i].data);
         busy_cnt  = 0;
         done_seen = 1'b0;
         for (int k = 0; k < 20000; k++) begin
            if (o_tx_done) begin
               done_seen = 1'b1;
               break;
            end
            if (o_busy) busy_cnt++;
            @(negedge clock);
         end
         check($sformatf("vec%0d_done", i), int'(done_seen), 1);
         check($sformatf("vec%0d_clocks", i), busy_cnt, FB * OVS * vecs[i].period);
      end

      // Start held high, data changed mid-frame: back-to-back frames.
      tick_period = 1;
      wait_idle();
      @(negedge clock);
      i_data     = 8'h55;
      i_tx_start = 1'b1;
      exp_q.push_back(frame_of(8'h55));
      repeat (50) @(negedge clock);
      i_data = 8'hAA;
      exp_q.push_back(frame_of(8'hAA));
      wait_done();
      check("b2b_done_busy", int'(o_busy), 0);
      @(negedge clock);
      check("b2b_restart_busy", int'(o_busy), 1);
      check("b2b_restart_tx", int'(o_tx), 0);
      i_tx_start = 1'b0;
      i_data     = 8'h00;
      wait_done();

      // Reset during data bit 3 aborts without a done pulse.
      aborts_allowed = 1;
      send(8'hC3);
      repeat (70) @(negedge clock);
      i_reset = 1'b1;
      @(negedge clock);
      check("abort_tx", int'(o_tx), 1);
      check("abort_busy", int'(o_busy), 0);
      check("abort_done", int'(o_tx_done), 0);
      i_reset  = 1'b0;
      done_any = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock);
         done_any |= o_tx_done;
      end
      check("abort_no_done", int'(done_any), 0);
      send(8'h96);
      wait_done();

      // Ticks stalled for 100 clocks inside the start bit.
      send(8'h81);
      repeat (5) @(negedge clock);
      tick_gate = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         check($sformatf("stall_tx_%0d", k), int'(o_tx), 0);
      end
      tick_gate = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (o_tx == 1'b0 && n < 1000);
      check("stall_resume_clocks", n, OVS - 5);
      wait_done();

      repeat (20) @(negedge clock);
      check("sb_empty", exp_q.size(), 0);
      check("aborts_seen", aborts_seen, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
